// File: rtl/dino_jump_fsm_if.sv
// Purpose: bundles the jump engine's control inputs and trajectory outputs for one lane.
// Latency: none; this file only carries signals.
// Backpressure: none; all signals are plain levels or single-cycle pulses.
interface dino_jump_fsm_if #(
  parameter int Y_W = 9
);
  logic           tick_src;
  logic           jump_req;
  logic           freeze;
  logic [Y_W-1:0] dino_y;
  logic           airborne;
  logic [5:0]     jump_cnt;
  logic           apex;
  logic           landed;

  // Driver side: keypad/PS2 decode, divider and crash logic.
  modport master (
    output tick_src, jump_req, freeze,
    input  dino_y, airborne, jump_cnt, apex, landed
  );

  // Jump engine side.
  modport slave (
    input  tick_src, jump_req, freeze,
    output dino_y, airborne, jump_cnt, apex, landed
  );
endinterface

// File: rtl/dino_jump_fsm.sv
// Purpose: per-lane dino jump engine; turns a jump_req pulse into a 64-tick Y trajectory.
// Latency: a tick rising edge is acted on when detected; dino_y/jump_cnt/pulses update one clk later.
// Backpressure: none; freeze holds all state. Optional landing jump buffer: DINO_JUMP_BUFFER_EN.
module dino_jump_fsm #(
  parameter int GROUND_Y  = 146,
  parameter int Y_W       = 9,
  parameter int BUF_TICKS = 8
) (
  input  logic             clk,
  input  logic             rst,
  dino_jump_fsm_if.slave   jmp
);

  // Reject parameterizations that could underflow Y or overrun the descent window.
  if (GROUND_Y < 124 || GROUND_Y >= (1 << Y_W) || BUF_TICKS < 1 || BUF_TICKS > 32) begin : g_param_check
    $error("dino_jump_fsm: illegal GROUND_Y/Y_W/BUF_TICKS combination");
  end

  typedef enum logic [1:0] {
    ST_GROUND  = 2'd0,
    ST_ASCEND  = 2'd1,
    ST_DESCEND = 2'd2
  } state_e;

  localparam logic [Y_W-1:0] GROUND = Y_W'(GROUND_Y);

  state_e         state_q, state_d;
  logic           tick_q;
  logic [Y_W-1:0] y_q, y_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           apex_q, apex_d;
  logic           landed_q, landed_d;
  logic           tick;
  logic           start_req;
  logic [2:0]     step;
  logic [Y_W-1:0] step_y;

`ifdef DINO_JUMP_BUFFER_EN
  localparam logic [5:0] BUF_START = 6'(64 - BUF_TICKS);
  logic pend_q, pend_d;
`endif

  assign tick = jmp.tick_src & ~tick_q;

  // A buffered request launches the next jump one cycle after landing.
`ifdef DINO_JUMP_BUFFER_EN
  assign start_req = jmp.jump_req | pend_q;
`else
  assign start_req = jmp.jump_req;
`endif

  // Step size: fast near the ground, slow near the apex; symmetric 124 up / 124 down.
  always_comb begin
    step = 3'd2;
    if (cnt_q < 6'd10 || cnt_q >= 6'd54) begin
      step = 3'd6;
    end else if (cnt_q < 6'd20 || cnt_q >= 6'd44) begin
      step = 3'd4;
    end
    step_y = Y_W'(step);
  end

  // Next-state, trajectory and pulse generation; freeze leaves everything at its held value.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    cnt_d    = cnt_q;
    apex_d   = 1'b0;
    landed_d = 1'b0;
`ifdef DINO_JUMP_BUFFER_EN
    pend_d   = pend_q;
`endif
    if (!jmp.freeze) begin
      unique case (state_q)
        ST_GROUND: begin
          y_d   = GROUND;
          cnt_d = 6'd0;
          // A tick coinciding with the request is dropped: first move is on the next tick.
          if (start_req) begin
            state_d = ST_ASCEND;
`ifdef DINO_JUMP_BUFFER_EN
            pend_d  = 1'b0;
`endif
          end
        end
        ST_ASCEND: begin
          if (tick) begin
            y_d   = y_q - step_y;
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == 6'd31) begin
              state_d = ST_DESCEND;
              apex_d  = 1'b1;
            end
          end
        end
        ST_DESCEND: begin
`ifdef DINO_JUMP_BUFFER_EN
          if (jmp.jump_req && cnt_q >= BUF_START) begin
            pend_d = 1'b1;
          end
`endif
          if (tick) begin
            if (cnt_q == 6'd63) begin
              state_d  = ST_GROUND;
              y_d      = GROUND;
              cnt_d    = 6'd0;
              landed_d = 1'b1;
            end else begin
              y_d   = y_q + step_y;
              cnt_d = cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_d = ST_GROUND;
          y_d     = GROUND;
          cnt_d   = 6'd0;
        end
      endcase
    end
  end

  // State register; tick history keeps tracking tick_src even while frozen so held edges are lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_GROUND;
      tick_q   <= 1'b0;
      y_q      <= GROUND;
      cnt_q    <= 6'd0;
      apex_q   <= 1'b0;
      landed_q <= 1'b0;
`ifdef DINO_JUMP_BUFFER_EN
      pend_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      tick_q   <= jmp.tick_src;
      y_q      <= y_d;
      cnt_q    <= cnt_d;
      apex_q   <= apex_d;
      landed_q <= landed_d;
`ifdef DINO_JUMP_BUFFER_EN
      pend_q   <= pend_d;
`endif
    end
  end

  assign jmp.dino_y   = y_q;
  assign jmp.airborne = (state_q != ST_GROUND);
  assign jmp.jump_cnt = cnt_q;
  // Pulses are suppressed for as long as the crash hold is asserted.
  assign jmp.apex     = apex_q & ~jmp.freeze;
  assign jmp.landed   = landed_q & ~jmp.freeze;

endmodule
